// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU definitions: datapath width, ALU select codes and the
// multiply sequencer state encoding.
package alu_mul_sequencer_pkg;

   localparam int unsigned DATA_W    = 19;
   localparam int unsigned ALU_SEL_W = 4;

   localparam logic [ALU_SEL_W-1:0] ALU_INCR = 4'd0;
   localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd1;
   localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd2;
   localparam logic [ALU_SEL_W-1:0] ALU_SHL  = 4'd3;
   localparam logic [ALU_SEL_W-1:0] ALU_SHR  = 4'd4;
   localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_ADD_ISS,
      S_ADD_CAP,
      S_SHL_ISS,
      S_SHL_CAP,
      S_SHR_ISS,
      S_SHR_CAP,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// ALU port bundle: select/operands towards the ALU, registered result back.
interface alu_mul_sequencer_if
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned SEL_W = ALU_SEL_W
);
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;

   modport master (output alu_sel, output alu_a, output alu_b, input alu_out);
   modport slave  (input alu_sel, input alu_a, input alu_b, output alu_out);
endinterface

// File: rtl/alu_mul_sequencer_port_mux.sv
// Chooses who drives the ALU: the control unit when idle, the sequencer when busy.
module alu_mul_sequencer_port_mux
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned SEL_W = ALU_SEL_W
) (
   input  logic             busy,
   input  logic [SEL_W-1:0] cu_alu_sel,
   input  logic [WIDTH-1:0] cu_a,
   input  logic [WIDTH-1:0] cu_b,
   input  logic [SEL_W-1:0] seq_sel,
   input  logic [WIDTH-1:0] seq_a,
   input  logic [WIDTH-1:0] seq_b,
   output logic [SEL_W-1:0] alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b
);

   // Same-cycle passthrough while idle; sequencer owns the ALU otherwise.
   always_comb begin
      alu_sel = cu_alu_sel;
      alu_a   = cu_a;
      alu_b   = cu_b;
      if (busy) begin
         alu_sel = seq_sel;
         alu_a   = seq_a;
         alu_b   = seq_b;
      end
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU; control-unit ALU
// requests pass straight through while no multiply is in progress.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned SEL_W = ALU_SEL_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    op_a,
   input  logic [WIDTH-1:0]    op_b,
   input  logic [SEL_W-1:0]    cu_alu_sel,
   input  logic [WIDTH-1:0]    cu_a,
   input  logic [WIDTH-1:0]    cu_b,
   alu_mul_sequencer_if.master alu_bus,
   output logic                busy,
   output logic                cu_stall,
   output logic                done,
   output logic [WIDTH-1:0]    product
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   seq_state_t       state;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] seq_sel;
   logic [WIDTH-1:0] seq_a;
   logic [WIDTH-1:0] seq_b;
   logic [SEL_W-1:0] mux_sel;
   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;

   // Multiply FSM. The ALU drive is registered, so each branch loads the
   // drive for the state being entered: issue states get their operation,
   // every other busy state gets ADD P,0 using the P value it will see.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         p       <= '0;
         m       <= '0;
         q       <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         seq_sel <= SEL_W'(ALU_ADD);
         seq_a   <= '0;
         seq_b   <= '0;
      end else begin
         done    <= 1'b0;
         seq_sel <= SEL_W'(ALU_ADD);
         seq_a   <= p;
         seq_b   <= '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  m     <= op_a;
                  q     <= op_b;
                  p     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  seq_a <= '0;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (q == '0 || cnt == CNT_W'(WIDTH)) begin
                  product <= p;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (q[0]) begin
                  seq_b <= m;
                  state <= S_ADD_ISS;
               end else begin
                  seq_sel <= SEL_W'(ALU_SHL);
                  seq_a   <= m;
                  seq_b   <= WIDTH'(1);
                  state   <= S_SHL_ISS;
               end
            end
            S_ADD_ISS: state <= S_ADD_CAP;
            S_ADD_CAP: begin
               p       <= alu_bus.alu_out;
               seq_sel <= SEL_W'(ALU_SHL);
               seq_a   <= m;
               seq_b   <= WIDTH'(1);
               state   <= S_SHL_ISS;
            end
            S_SHL_ISS: state <= S_SHL_CAP;
            S_SHL_CAP: begin
               m       <= alu_bus.alu_out;
               seq_sel <= SEL_W'(ALU_SHR);
               seq_a   <= q;
               seq_b   <= WIDTH'(1);
               state   <= S_SHR_ISS;
            end
            S_SHR_ISS: state <= S_SHR_CAP;
            S_SHR_CAP: begin
               q     <= alu_bus.alu_out;
               cnt   <= cnt + CNT_W'(1);
               state <= S_CHECK;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stall mirrors busy so the control unit never fights for the ALU.
   always_comb cu_stall = busy;

   alu_mul_sequencer_port_mux #(
      .WIDTH(WIDTH),
      .SEL_W(SEL_W)
   ) u_port_mux (
      .busy      (busy),
      .cu_alu_sel(cu_alu_sel),
      .cu_a      (cu_a),
      .cu_b      (cu_b),
      .seq_sel   (seq_sel),
      .seq_a     (seq_a),
      .seq_b     (seq_b),
      .alu_sel   (mux_sel),
      .alu_a     (mux_a),
      .alu_b     (mux_b)
   );

   // Forward the mux result onto the ALU bus.
   always_comb begin
      alu_bus.alu_sel = mux_sel;
      alu_bus.alu_a   = mux_a;
      alu_bus.alu_b   = mux_b;
   end

endmodule
